// File: rtl/cpu_pkg.sv
// Shared RV32I definitions for the decode/issue slice: widths, opcodes and
// the immediate-format classification used by decode and immediate generation.
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILL
  } imm_fmt_e;

  // Anything outside the RV32I base opcode map is classified as illegal.
  function automatic imm_fmt_e fmt_of(input logic [6:0] opc);
    imm_fmt_e f;
    case (opc)
      OPC_OP:                                                      f = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM:    f = FMT_I;
      OPC_STORE:                                                   f = FMT_S;
      OPC_BRANCH:                                                  f = FMT_B;
      OPC_LUI, OPC_AUIPC:                                          f = FMT_U;
      OPC_JAL:                                                     f = FMT_J;
      default:                                                     f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch, writeback, flush and issue signals of the decode/issue stage.
// The slave modport is the decode_issue side; master drives it.
interface decode_issue_if;
  import cpu_pkg::*;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [5:0]      rs1_addr;
  logic [5:0]      rs2_addr;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            flush;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_instr;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic            ex_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, wb_valid, wb_rd, flush, ex_ready,
    output if_ready, rs1_addr, rs2_addr, ex_valid, ex_pc, ex_instr, ex_imm,
           ex_rd, ex_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, wb_valid, wb_rd, flush, ex_ready,
    input  if_ready, rs1_addr, rs2_addr, ex_valid, ex_pc, ex_instr, ex_imm,
           ex_rd, ex_illegal
  );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; R-type and illegal words yield 0.
module imm_gen
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o
);

  // Format classification and sign-extended immediate assembly
  always_comb begin
    fmt_o = fmt_of(instr_i[6:0]);
    imm_o = {XLEN{1'b0}};
    case (fmt_o)
      FMT_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U:   imm_o = {instr_i[31:12], 12'h000};
      FMT_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/decode_issue.sv
// Two-entry decode/issue stage: D holds the fetched word, E presents it to
// execute. A busy scoreboard stalls D on RAW/WAW against in-flight writers.
module decode_issue
  import cpu_pkg::*;
(
  input logic          CLK,
  input logic          RESET,
  decode_issue_if.slave bus
);

  logic             d_valid_q, d_valid_d;
  logic [XLEN-1:0]  d_instr_q, d_instr_d;
  logic [XLEN-1:0]  d_pc_q, d_pc_d;
  logic             ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]  ex_instr_q, ex_instr_d;
  logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_illegal_q, ex_illegal_d;
  logic [NREGS-1:0] busy_q, busy_d;

  logic [XLEN-1:0]  d_imm_s;
  imm_fmt_e         d_fmt_s;
  logic             uses_rs1_s, uses_rs2_s, writes_rd_s;
  logic [4:0]       rs1_s, rs2_s, d_rd_s;
  logic             hazard_s, d_advance_s, if_ready_s, fetch_s, flush_clr_s;

  imm_gen u_imm_gen (
    .instr_i (d_instr_q),
    .imm_o   (d_imm_s),
    .fmt_o   (d_fmt_s)
  );

  // Register usage of the word in D, derived from its encoding format
  always_comb begin
    uses_rs1_s  = 1'b0;
    uses_rs2_s  = 1'b0;
    writes_rd_s = 1'b0;
    case (d_fmt_s)
      FMT_R:        begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; writes_rd_s = 1'b1; end
      FMT_I:        begin uses_rs1_s = 1'b1; writes_rd_s = 1'b1; end
      FMT_S, FMT_B: begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
      FMT_U, FMT_J: begin writes_rd_s = 1'b1; end
      default:      begin writes_rd_s = 1'b0; end
    endcase
  end

  assign rs1_s  = d_instr_q[19:15];
  assign rs2_s  = d_instr_q[24:20];
  assign d_rd_s = writes_rd_s ? d_instr_q[11:7] : 5'd0;

  // busy[0] is never set, so an x0 destination can never raise WAW
  assign hazard_s = (uses_rs1_s && busy_q[rs1_s]) ||
                    (uses_rs2_s && busy_q[rs2_s]) ||
                    busy_q[d_rd_s];

  // Flush suppresses advance so killed work never sets a busy bit
  assign d_advance_s = d_valid_q && !hazard_s && (!ex_valid_q || bus.ex_ready) && !bus.flush;
  assign if_ready_s  = (!d_valid_q || d_advance_s) && !bus.flush;
  assign fetch_s     = bus.if_valid && if_ready_s;
  assign flush_clr_s = bus.flush && ex_valid_q && !bus.ex_ready;

  // Next-state for the decode register
  always_comb begin
    d_valid_d = d_valid_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    if (bus.flush) begin
      d_valid_d = 1'b0;
    end else if (fetch_s) begin
      d_valid_d = 1'b1;
      d_instr_d = bus.if_instr;
      d_pc_d    = bus.if_pc;
    end else if (d_advance_s) begin
      d_valid_d = 1'b0;
    end else begin
      d_valid_d = d_valid_q;
    end
  end

  // Next-state for the issue register; data holds once drained
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_instr_d   = ex_instr_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_illegal_d = ex_illegal_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (d_advance_s) begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = d_pc_q;
      ex_instr_d   = d_instr_q;
      ex_imm_d     = d_imm_s;
      ex_rd_d      = d_rd_s;
      ex_illegal_d = (d_fmt_s == FMT_ILL);
    end else if (ex_valid_q && bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // Scoreboard update: a set from issue wins over any clear of the same index
  always_comb begin
    busy_d = {NREGS{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      busy_d[i] = (d_advance_s && (d_rd_s == i[4:0])) ||
                  (busy_q[i] && !(bus.wb_valid && (bus.wb_rd == i[4:0])) &&
                                !(flush_clr_s && (ex_rd_q == i[4:0])));
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      d_valid_q    <= 1'b0;
      d_instr_q    <= {XLEN{1'b0}};
      d_pc_q       <= {XLEN{1'b0}};
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= {XLEN{1'b0}};
      ex_instr_q   <= {XLEN{1'b0}};
      ex_imm_q     <= {XLEN{1'b0}};
      ex_rd_q      <= 5'd0;
      ex_illegal_q <= 1'b0;
      busy_q       <= {NREGS{1'b0}};
    end else begin
      d_valid_q    <= d_valid_d;
      d_instr_q    <= d_instr_d;
      d_pc_q       <= d_pc_d;
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_instr_q   <= ex_instr_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_illegal_q <= ex_illegal_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.if_ready   = if_ready_s;
  assign bus.rs1_addr   = {1'b0, rs1_s};
  assign bus.rs2_addr   = {1'b0, rs2_s};
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_pc      = ex_pc_q;
  assign bus.ex_instr   = ex_instr_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: expected issues are queued when fetched
// and checked in order whenever the execute handshake completes.
module tb_decode_issue;

  logic clk;
  logic rst;

  decode_issue_if bus ();

  decode_issue dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] imm, input logic [4:0] rd, input logic ill);
    exp_t e;
    e.pc = pc; e.instr = instr; e.imm = imm; e.rd = rd; e.ill = ill;
    q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    bus.if_instr = instr;
  endtask

  // One clock: check any issue handshake at negedge, then step past posedge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.ex_valid === 1'b1 && bus.ex_ready === 1'b1) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_pc",    bus.ex_pc,               e.pc);
        chk("sb_instr", bus.ex_instr,            e.instr);
        chk("sb_imm",   bus.ex_imm,              e.imm);
        chk("sb_rd",    32'(bus.ex_rd),          32'(e.rd));
        chk("sb_ill",   32'(bus.ex_illegal),     32'(e.ill));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ins;
    rst          = 1'b1;
    bus.if_valid = 1'b0;
    bus.if_instr = 32'h0;
    bus.if_pc    = 32'h0;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = 5'd0;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ex_valid", 32'(bus.ex_valid),   32'd0);
    chk("rst_ex_pc",    bus.ex_pc,           32'd0);
    chk("rst_ex_instr", bus.ex_instr,        32'd0);
    chk("rst_ex_imm",   bus.ex_imm,          32'd0);
    chk("rst_ex_rd",    32'(bus.ex_rd),      32'd0);
    chk("rst_ex_ill",   32'(bus.ex_illegal), 32'd0);
    chk("rst_if_ready", 32'(bus.if_ready),   32'd1);
    chk("rst_busy",     dut.busy_q,          32'd0);

    // addi x1,x0,5: two-edge latency, busy[1] set
    drive(32'h100, 32'h00500093);
    push(32'h100, 32'h00500093, 32'd5, 5'd1, 1'b0);
    tick();
    bus.if_valid = 1'b0;
    chk("lat_e_empty", 32'(bus.ex_valid), 32'd0);
    tick();
    chk("lat_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("lat_ex_imm",   bus.ex_imm,        32'd5);
    chk("lat_ex_rd",    32'(bus.ex_rd),    32'd1);
    chk("lat_busy1",    32'(dut.busy_q[1]), 32'd1);
    tick();
    chk("drain_ex_valid", 32'(bus.ex_valid), 32'd0);

    // RAW stall: addi x1 then add x2,x1,x1
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1;
    tick();
    bus.wb_valid = 1'b0;
    chk("wb_clear", dut.busy_q, 32'd0);
    drive(32'h104, 32'h00700093);
    push(32'h104, 32'h00700093, 32'd7, 5'd1, 1'b0);
    tick();
    drive(32'h108, 32'h00108133);
    push(32'h108, 32'h00108133, 32'd0, 5'd2, 1'b0);
    tick();
    bus.if_valid = 1'b0;
    chk("raw_rs1", 32'(bus.rs1_addr), 32'd1);
    chk("raw_rs2", 32'(bus.rs2_addr), 32'd1);
    chk("raw_if_ready", 32'(bus.if_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("raw_stall_valid", 32'(bus.ex_valid), 32'd0);
    end
    chk("raw_e_hold_rd", 32'(bus.ex_rd), 32'd1);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1;
    tick();
    bus.wb_valid = 1'b0;
    chk("raw_wb_edge", 32'(bus.ex_valid), 32'd0);
    tick();
    chk("raw_issue_valid", 32'(bus.ex_valid), 32'd1);
    chk("raw_issue_rd",    32'(bus.ex_rd),    32'd2);
    tick();

    // Backpressure with D and E full
    bus.ex_ready = 1'b0;
    drive(32'h200, 32'h00100193);
    push(32'h200, 32'h00100193, 32'd1, 5'd3, 1'b0);
    tick();
    drive(32'h204, 32'h00200213);
    push(32'h204, 32'h00200213, 32'd2, 5'd4, 1'b0);
    tick();
    drive(32'h208, 32'h00300293);
    push(32'h208, 32'h00300293, 32'd3, 5'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_if_ready", 32'(bus.if_ready), 32'd0);
      chk("bp_ex_valid", 32'(bus.ex_valid), 32'd1);
      chk("bp_ex_pc",    bus.ex_pc,         32'h200);
      chk("bp_ex_instr", bus.ex_instr,      32'h00100193);
      tick();
    end
    bus.ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.if_ready), 32'd1);
    tick();
    bus.if_valid = 1'b0;
    tick();
    tick();
    chk("bp_drained", 32'(bus.ex_valid), 32'd0);
    chk("bp_sb_empty", 32'(q.size()), 32'd0);

    // Flush of an unaccepted addi x3, with a simultaneous fetch
    for (int r = 2; r <= 5; r++) begin
      bus.wb_valid = 1'b1; bus.wb_rd = 5'(r);
      tick();
    end
    bus.wb_valid = 1'b0;
    chk("busy_all_clear", dut.busy_q, 32'd0);
    bus.ex_ready = 1'b0;
    drive(32'h300, 32'h00900193);
    push(32'h300, 32'h00900193, 32'd9, 5'd3, 1'b0);
    tick();
    bus.if_valid = 1'b0;
    tick();
    chk("fl_pre_valid", 32'(bus.ex_valid), 32'd1);
    chk("fl_pre_busy3", 32'(dut.busy_q[3]), 32'd1);
    bus.flush = 1'b1;
    drive(32'h304, 32'h00100313);
    #1;
    chk("fl_if_ready", 32'(bus.if_ready), 32'd0);
    tick();
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    q.delete();
    chk("fl_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("fl_busy",     dut.busy_q,        32'd0);
    tick();
    chk("fl_discard", 32'(bus.ex_valid), 32'd0);
    bus.ex_ready = 1'b1;
    tick();
    chk("fl_discard2", 32'(bus.ex_valid), 32'd0);

    // beq immediate, illegal opcode, lui
    drive(32'h400, 32'hFE000CE3);
    push(32'h400, 32'hFE000CE3, 32'hFFFFFFF8, 5'd0, 1'b0);
    tick();
    drive(32'h404, 32'h00000FFF);
    push(32'h404, 32'h00000FFF, 32'd0, 5'd0, 1'b1);
    tick();
    chk("beq_imm",  bus.ex_imm,     32'hFFFFFFF8);
    chk("beq_rd",   32'(bus.ex_rd), 32'd0);
    chk("beq_busy", dut.busy_q,     32'd0);
    drive(32'h408, 32'h123453B7);
    push(32'h408, 32'h123453B7, 32'h12345000, 5'd7, 1'b0);
    tick();
    bus.if_valid = 1'b0;
    chk("ill_flag", 32'(bus.ex_illegal), 32'd1);
    chk("ill_rd",   32'(bus.ex_rd),      32'd0);
    chk("ill_busy", dut.busy_q,          32'd0);
    tick();
    chk("lui_imm",   bus.ex_imm,          32'h12345000);
    chk("lui_busy7", 32'(dut.busy_q[7]),  32'd1);
    tick();

    // Reset during a RAW stall with busy[1..5] set
    for (int r = 1; r <= 5; r++) begin
      ins = {r[11:0], 5'd0, 3'd0, r[4:0], 7'h13};
      drive(32'h500 + 32'(4 * r), ins);
      push(32'h500 + 32'(4 * r), ins, 32'(r), r[4:0], 1'b0);
      tick();
    end
    drive(32'h520, 32'h00108333);
    tick();
    bus.if_valid = 1'b0;
    tick();
    chk("rs_busy_1_5",   32'(dut.busy_q[5:1]), 32'h1F);
    chk("rs_stall",      32'(bus.if_ready),    32'd0);
    chk("rs_pre_valid",  32'(bus.ex_valid),    32'd0);
    rst          = 1'b1;
    bus.flush    = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    bus.ex_ready = 1'b0;
    drive(32'h600, 32'h00100093);
    tick();
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.wb_valid = 1'b0;
    bus.if_valid = 1'b0;
    bus.ex_ready = 1'b1;
    #1;
    chk("rs_busy",     dut.busy_q,        32'd0);
    chk("rs_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rs_if_ready", 32'(bus.if_ready), 32'd1);
    chk("rs_ex_pc",    bus.ex_pc,         32'd0);
    chk("rs_ex_rd",    32'(bus.ex_rd),    32'd0);
    tick();
    chk("rs_empty", 32'(bus.ex_valid), 32'd0);
    chk("sb_final_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
